// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Optional macro BTB_UPDATE_FWD_EN adds same-cycle update-to-lookup forwarding.
module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  output logic        pred_valid,
  output logic        predicted_taken,
  output logic [31:0] predicted_pc,
  input  logic        update_btb,
  input  logic [31:0] update_pc,
  input  logic [31:0] update_target,
  input  logic        update_taken,
  input  logic        update_uncond,
  input  logic        btb_flush
);

  localparam int TAG_W = 30 - IDX_W;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  logic [ENTRIES-1:0]      valid_q, valid_d;
  logic [ENTRIES-1:0][1:0] ctr_q, ctr_d;
  tag_t                    tag_q    [ENTRIES];
  logic [31:0]             target_q [ENTRIES];

  idx_t fetch_idx, upd_idx;
  tag_t fetch_tag, upd_tag;

  assign fetch_idx = fetch_pc[IDX_W+1:2];
  assign fetch_tag = fetch_pc[31:IDX_W+2];
  assign upd_idx   = update_pc[IDX_W+1:2];
  assign upd_tag   = update_pc[31:IDX_W+2];

  // Byte offset within the word never participates in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[1:0], update_pc[1:0]};

  logic       upd_hit;
  logic       state_we;
  logic       tgt_we;
  logic [1:0] upd_cur;
  logic [1:0] upd_ctr;

  // NOTE: every output of a combinational block gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_cur  = ctr_q[upd_idx];
    upd_ctr  = upd_cur;
    state_we = 1'b0;
    tgt_we   = 1'b0;
    if (update_btb) begin
      if (upd_hit) begin
        state_we = 1'b1;
        if (update_uncond) begin
          upd_ctr = CTR_ST;
          tgt_we  = 1'b1;
        end else if (update_taken) begin
          upd_ctr = (upd_cur == CTR_ST) ? CTR_ST : upd_cur + 2'd1;
          tgt_we  = 1'b1;
        end else begin
          upd_ctr = (upd_cur == CTR_SNT) ? CTR_SNT : upd_cur - 2'd1;
        end
      end else if (update_taken) begin
        // Allocation overwrites whatever currently occupies the slot.
        state_we = 1'b1;
        tgt_we   = 1'b1;
        upd_ctr  = update_uncond ? CTR_ST : CTR_WT;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    ctr_d   = ctr_q;
    if (btb_flush) begin
      valid_d = '0;
      ctr_d   = {ENTRIES{CTR_WNT}};
    end else if (state_we) begin
      valid_d[upd_idx] = 1'b1;
      ctr_d[upd_idx]   = upd_ctr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      ctr_q   <= {ENTRIES{CTR_WNT}};
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // NOTE: tag and target storage is deliberately not reset; a cleared valid
  // bit already masks them, and leaving them reset-free lets them map to RAM.
  always_ff @(posedge clk) begin
    if (rst && !btb_flush && tgt_we) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= update_target;
    end
  end

  logic        look_valid;
  tag_t        look_tag;
  logic [31:0] look_target;
  logic [1:0]  look_ctr;

  always_comb begin
    look_valid  = valid_q[fetch_idx];
    look_tag    = tag_q[fetch_idx];
    look_target = target_q[fetch_idx];
    look_ctr    = ctr_q[fetch_idx];
`ifdef BTB_UPDATE_FWD_EN
    if (state_we && (upd_idx == fetch_idx)) begin
      look_valid = 1'b1;
      look_ctr   = upd_ctr;
      if (tgt_we) begin
        look_tag    = upd_tag;
        look_target = update_target;
      end
    end
    if (btb_flush) begin
      look_valid = 1'b0;
    end
`endif
  end

  assign pred_valid      = look_valid && (look_tag == fetch_tag);
  assign predicted_taken = pred_valid && look_ctr[1];
  assign predicted_pc    = predicted_taken ? look_target : fetch_pc + 32'd4;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer (default build): directed
// vector table, reset sequences, and random traffic against an array model.
module tb_branch_target_buffer;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        pred_valid;
  logic        predicted_taken;
  logic [31:0] predicted_pc;
  logic        update_btb;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        update_taken;
  logic        update_uncond;
  logic        btb_flush;

  branch_target_buffer #(.ENTRIES(ENTRIES)) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_pc        (fetch_pc),
    .pred_valid      (pred_valid),
    .predicted_taken (predicted_taken),
    .predicted_pc    (predicted_pc),
    .update_btb      (update_btb),
    .update_pc       (update_pc),
    .update_target   (update_target),
    .update_taken    (update_taken),
    .update_uncond   (update_uncond),
    .btb_flush       (btb_flush)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one record per slot, tag kept as the PC's upper bits.
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];

  typedef struct {
    logic [31:0] fpc;
    logic        upd;
    logic [31:0] upc;
    logic [31:0] utgt;
    logic        taken;
    logic        unc;
    logic        flush;
    logic        ev;
    logic        et;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs [25];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
  endtask

  task automatic model_lookup(input logic [31:0] pc, output logic v, output logic t,
                              output logic [31:0] npc);
    int i;
    i   = int'((pc >> 2) % ENTRIES);
    v   = m_valid[i] && (m_tag[i] == (pc >> (IDX_W + 2)));
    t   = v && (m_ctr[i] >= 2);
    npc = t ? m_target[i] : pc + 32'd4;
  endtask

  task automatic model_edge(input logic upd, input logic [31:0] upc, input logic [31:0] utgt,
                            input logic taken, input logic unc, input logic flush);
    int i;
    bit hit;
    if (flush) begin
      model_reset();
    end else if (upd) begin
      i   = int'((upc >> 2) % ENTRIES);
      hit = m_valid[i] && (m_tag[i] == (upc >> (IDX_W + 2)));
      if (hit) begin
        if (unc) begin
          m_ctr[i] = 3; m_target[i] = utgt;
        end else if (taken) begin
          m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1; m_target[i] = utgt;
        end else begin
          m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (taken) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = upc >> (IDX_W + 2);
        m_target[i] = utgt;
        m_ctr[i]    = unc ? 3 : 2;
      end
    end
  endtask

  task automatic drive(input vec_t v);
    fetch_pc      = v.fpc;
    update_btb    = v.upd;
    update_pc     = v.upc;
    update_target = v.utgt;
    update_taken  = v.taken;
    update_uncond = v.unc;
    btb_flush     = v.flush;
  endtask

  task automatic clock_edge(input vec_t v);
    @(posedge clk);
    model_edge(v.upd, v.upc, v.utgt, v.taken, v.unc, v.flush);
    #1;
  endtask

  function automatic vec_t mkv(input logic [31:0] fpc, input logic upd, input logic [31:0] upc,
                               input logic [31:0] utgt, input logic taken, input logic unc,
                               input logic flush, input logic ev, input logic et,
                               input logic [31:0] epc);
    vec_t v;
    v.fpc = fpc; v.upd = upd; v.upc = upc; v.utgt = utgt; v.taken = taken;
    v.unc = unc; v.flush = flush; v.ev = ev; v.et = et; v.epc = epc;
    return v;
  endfunction

  function automatic vec_t look(input logic [31:0] fpc, input logic ev, input logic et,
                                input logic [31:0] epc);
    return mkv(fpc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, ev, et, epc);
  endfunction

  // Lookup-only cycle checked against the model.
  task automatic model_look_check(input string name, input logic [31:0] pc);
    logic ev, et;
    logic [31:0] epc;
    drive(look(pc, 1'b0, 1'b0, 32'h0));
    #1;
    model_lookup(pc, ev, et, epc);
    check({name, ".valid"}, {31'b0, pred_valid}, {31'b0, ev});
    check({name, ".taken"}, {31'b0, predicted_taken}, {31'b0, et});
    check({name, ".pc"}, predicted_pc, epc);
    clock_edge(look(pc, 1'b0, 1'b0, 32'h0));
  endtask

  initial begin
    // Hand-computed expectations; entries: idx=pc[5:2], tag=pc[31:6].
    vecs[0]  = mkv(32'h1000, 1, 32'h1000, 32'h2000, 1, 0, 0, 0, 0, 32'h1004);
    vecs[1]  = mkv(32'h1000, 1, 32'h1000, 32'h0,    0, 0, 0, 1, 1, 32'h2000);
    vecs[2]  = mkv(32'h1000, 1, 32'h1000, 32'h0,    0, 0, 0, 1, 0, 32'h1004);
    vecs[3]  = mkv(32'h1000, 1, 32'h1000, 32'h0,    0, 0, 0, 1, 0, 32'h1004);
    vecs[4]  = mkv(32'h1000, 1, 32'h1000, 32'h2000, 1, 0, 0, 1, 0, 32'h1004);
    vecs[5]  = look(32'h1000, 1, 0, 32'h1004);
    vecs[6]  = mkv(32'h1040, 1, 32'h1040, 32'h3000, 1, 0, 0, 0, 0, 32'h1044);
    vecs[7]  = look(32'h1000, 0, 0, 32'h1004);
    vecs[8]  = look(32'h1040, 1, 1, 32'h3000);
    vecs[9]  = mkv(32'h2000, 1, 32'h2000, 32'h9999, 0, 0, 0, 0, 0, 32'h2004);
    vecs[10] = mkv(32'h2000, 1, 32'h2004, 32'h0,    1, 1, 0, 0, 0, 32'h2004);
    vecs[11] = look(32'h2004, 1, 1, 32'h0);
    vecs[12] = mkv(32'h1040, 1, 32'h1040, 32'h0,    0, 0, 0, 1, 1, 32'h3000);
    vecs[13] = look(32'h1040, 1, 0, 32'h1044);
    vecs[14] = mkv(32'h2004, 1, 32'h1000, 32'h5000, 1, 0, 1, 1, 1, 32'h0);
    vecs[15] = look(32'h1000, 0, 0, 32'h1004);
    vecs[16] = look(32'h2004, 0, 0, 32'h2008);
    vecs[17] = look(32'h1040, 0, 0, 32'h1044);
    vecs[18] = mkv(32'hFFFF_FFFC, 1, 32'h1040, 32'h3100, 1, 0, 0, 0, 0, 32'h0);
    vecs[19] = look(32'h1040, 1, 1, 32'h3100);
    vecs[20] = look(32'h1042, 1, 1, 32'h3100);
    vecs[21] = mkv(32'h0,    1, 32'h2004, 32'h100,  1, 1, 0, 0, 0, 32'h4);
    vecs[22] = mkv(32'h2004, 1, 32'h2004, 32'h200,  1, 0, 0, 1, 1, 32'h100);
    vecs[23] = mkv(32'h2004, 1, 32'h2004, 32'h0,    0, 0, 0, 1, 1, 32'h200);
    vecs[24] = look(32'h2004, 1, 1, 32'h200);

    // Reset held for two edges, with a pending update that must be dropped.
    rst = 1'b0;
    drive(mkv(32'h1000, 1, 32'h1000, 32'h7000, 1, 1, 0, 0, 0, 32'h0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    drive(look(32'h1000, 0, 0, 32'h0));
    #1;
    check("reset.valid", {31'b0, pred_valid}, 32'd0);
    check("reset.taken", {31'b0, predicted_taken}, 32'd0);
    check("reset.pc", predicted_pc, 32'h1004);
    clock_edge(look(32'h1000, 0, 0, 32'h0));

    for (int k = 0; k < 25; k++) begin
      drive(vecs[k]);
      #1;
      check($sformatf("vec%0d.valid", k), {31'b0, pred_valid}, {31'b0, vecs[k].ev});
      check($sformatf("vec%0d.taken", k), {31'b0, predicted_taken}, {31'b0, vecs[k].et});
      check($sformatf("vec%0d.pc", k), predicted_pc, vecs[k].epc);
      clock_edge(vecs[k]);
    end

    // Reset asserted mid-stream: the update in that cycle is dropped and
    // every previously valid entry is gone.
    rst = 1'b0;
    drive(mkv(32'h3000, 1, 32'h3000, 32'h4444, 1, 0, 0, 0, 0, 32'h0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    drive(look(32'h3000, 0, 0, 32'h0));
    #1;
    check("midrst.new.valid", {31'b0, pred_valid}, 32'd0);
    check("midrst.new.pc", predicted_pc, 32'h3004);
    clock_edge(look(32'h3000, 0, 0, 32'h0));
    drive(look(32'h2004, 0, 0, 32'h0));
    #1;
    check("midrst.old.valid", {31'b0, pred_valid}, 32'd0);
    check("midrst.old.pc", predicted_pc, 32'h2008);
    clock_edge(look(32'h2004, 0, 0, 32'h0));

    // Random traffic over a small PC pool so hits, aliasing and flushes occur.
    for (int n = 0; n < 400; n++) begin
      vec_t v;
      logic [31:0] bases [4];
      logic ev, et;
      logic [31:0] epc;
      bases[0] = 32'h0000_1000; bases[1] = 32'h0000_1040;
      bases[2] = 32'h8000_0000; bases[3] = 32'hFFFF_FF80;
      v.fpc   = bases[$urandom_range(0, 3)] + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      v.upc   = bases[$urandom_range(0, 3)] + ($urandom_range(0, 7) << 2);
      v.upd   = ($urandom_range(0, 1) == 1);
      v.utgt  = $urandom;
      v.unc   = ($urandom_range(0, 4) == 0);
      v.taken = v.unc | ($urandom_range(0, 2) != 0);
      v.flush = ($urandom_range(0, 39) == 0);
      drive(v);
      #1;
      model_lookup(v.fpc, ev, et, epc);
      check($sformatf("rnd%0d.valid", n), {31'b0, pred_valid}, {31'b0, ev});
      check($sformatf("rnd%0d.taken", n), {31'b0, predicted_taken}, {31'b0, et});
      check($sformatf("rnd%0d.pc", n), predicted_pc, epc);
      clock_edge(v);
    end

    model_look_check("final", 32'h0000_1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer with 2-bit saturating direction counters. It is the prediction source for the fetch stage and the update sink for branch resolution in execute. Fetch looks up `fetch_pc` combinationally and receives `pred_valid`, `predicted_taken` and `predicted_pc`. Execute writes resolved outcomes back one branch per cycle through the `update_*` port.

## Interface

Parameters:
- `ENTRIES`, default 16: number of entries; must be a power of two, 4 to 256.
- `IDX_W`, default `$clog2(ENTRIES)`: index width; derived, never overridden.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `fetch_pc`  in  32  PC being fetched this cycle.
- `pred_valid`  out  1  lookup hit: the entry is valid and its tag matches.
- `predicted_taken`  out  1  `pred_valid & counter[1]`.
- `predicted_pc`  out  32  stored target if `predicted_taken`, else `fetch_pc + 4` (wraps modulo 2^32).
- `update_btb`  in  1  update strobe from execute; one branch per cycle.
- `update_pc`  in  32  PC of the resolved branch or jump.
- `update_target`  in  32  resolved target address (`calc_jump_addr`).
- `update_taken`  in  1  actual outcome; always 1 for JAL/JALR.
- `update_uncond`  in  1  resolved instruction is JAL/JALR.
- `btb_flush`  in  1  invalidates every entry (`fence.i`, context change).

## Operation

- Address split:
  - index = `pc[IDX_W+1:2]`;
  - tag = `pc[31:IDX_W+2]`;
  - `pc[1:0]` is ignored.
- Per-entry state: `valid`, `tag`, `target[31:0]`, `ctr[1:0]`.
  - Counter encoding: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
- Lookup is purely combinational from the registered state (outputs defined above). There is no lookup enable.
- Update happens at the clock edge when `update_btb=1`, with hit = `valid[i] && tag[i]==update_tag`:
  - Hit and `update_uncond`: `ctr`←11, `target`←`update_target`.
  - Hit, conditional, taken: `ctr`←min(`ctr`+1, 11), `target`←`update_target`.
  - Hit, conditional, not taken: `ctr`←max(`ctr`−1, 00); target unchanged.
  - Miss and taken: allocate, overwriting any occupant. `valid`←1, `tag`, `target`←`update_target`; `ctr`←11 if `update_uncond`, else 10.
  - Miss and not taken: no state change, no allocation.
- `btb_flush=1` clears all `valid` bits and resets all `ctr` to 01 at the edge. Tags and targets are don't-care.
- Flush and update in the same cycle: flush wins and the update is discarded.

## Timing

- Lookup: zero-cycle latency, combinational `fetch_pc` → outputs.
- Update: state is visible to lookup from the cycle after the edge where `update_btb=1` is sampled (default build).
- Reset (`rst=0` sampled at an edge):
  - all `valid`←0, all `ctr`←01;
  - from the next cycle `pred_valid=0`, `predicted_taken=0`, `predicted_pc=fetch_pc+4`.
  - Reset overrides flush and update.
- Reset asserted mid-stream: any pending update in that cycle is dropped.
- Update while `update_btb=0`: all `update_*` inputs are ignored and may be X.
- Aliasing: two PCs with the same index and different tags evict each other (last allocation wins).
- Saturation: 11 + taken stays 11; 00 + not-taken stays 00.

## Configuration

- `BTB_UPDATE_FWD_EN` defined:
  - when `update_btb=1` and the update index equals the lookup index in the same cycle, the lookup outputs reflect the post-update entry (write-to-read forwarding);
  - flush in the same cycle forces `pred_valid=0`.
- Undefined: same-cycle lookup sees the pre-update entry, and all updates take effect one cycle later. No forwarding mux is present.

## Test plan

- Reset:
  - stimulus: `rst=0` for 2 cycles, then `fetch_pc=0x0000_1000`;
  - required: `pred_valid=0`, `predicted_taken=0`, `predicted_pc=0x0000_1004`.
- Allocate and hit:
  - stimulus: update pc `0x1000`, target `0x2000`, taken, conditional; next cycle lookup `0x1000`;
  - required: `pred_valid=1`, `predicted_taken=1` (ctr=10), `predicted_pc=0x2000`.
- Hysteresis:
  - stimulus: from ctr=10, two not-taken updates on `0x1000`;
  - required: after the first, `predicted_taken=0` (ctr=01) with `pred_valid` still 1; after the second, ctr=00; a third not-taken leaves it at 00.
- Aliasing:
  - stimulus: with ENTRIES=16, allocate `0x1000`, then allocate `0x1040` (same index 0, different tag) with target `0x3000`;
  - required: lookup `0x1000` gives `pred_valid=0` and `predicted_pc=0x1004`; lookup `0x1040` gives `predicted_pc=0x3000`.
- Miss not-taken and JAL:
  - stimulus: not-taken update on empty `0x2000`, then JAL update on `0x2004` with target `0x0`;
  - required: `0x2000` still misses; `0x2004` hits with `predicted_taken=1` (ctr=11).
- Flush and forwarding:
  - stimulus: `btb_flush` together with an update in the same cycle;
  - required: every lookup misses next cycle.
  - With `BTB_UPDATE_FWD_EN`: an update to `0x1000` while looking up `0x1000` shows `pred_valid=1` in that same cycle.
